device_event_queue: RTL
=======================

// Module: device_event_queue
// PURPOSE
//  Upstream feeder for the active-IoT-device counter. Watches N_DEV device status
//  lines, detects on/off transitions, and queues them per device.
//  Drains the queue as at most one {change, on_off} event per clock, so the
//  counter downstream never misses simultaneous transitions.
//  Net-zero toggle pairs are cancelled before issue.
// PARAMETERS
//  N_DEV  8  number of monitored devices (>=2)
//  ID_W   3  width of dev_id; must equal clog2(N_DEV)
// PORTS
//  clk         in   1      single clock; all logic on posedge
//  rst         in   1      synchronous reset, active-low (0 = reset)
//  dev_status  in   N_DEV  level per device: 1 = on, 0 = off; synchronous to clk
//  hold        in   1      1 = issue nothing this cycle; pending events are kept
//  change      out  1      registered; 1 = one event issued this cycle
//  on_off      out  1      registered; 1 = device turned on, 0 = off; valid only when change=1
//  dev_id      out  ID_W   registered; index of the device whose event is issued
//  busy        out  1      registered; 1 = at least one event still pending
// BEHAVIOUR
//  - Reset (rst=0 at posedge):
//    - change, on_off, dev_id, busy <= 0.
//    - prev_status <= 0; all pend_v <= 0.
//    - rr_ptr <= N_DEV-1, so device 0 is searched first.
//    - Devices already on when reset releases produce an "on" event, so the counter
//      starts correct from 0.
//    - Reset mid-operation discards all pending events.
//  - Edge detect: edge[i] = dev_status[i] ^ prev_status[i]; prev_status <= dev_status
//    every cycle. Edge direction = dev_status[i] (1 = rise/on).
//  - Per-device pending state: pend_v[i] and pend_dir[i].
//  - Grant: combinational round-robin over the registered pend_v.
//    - Search starts at rr_ptr+1 and wraps modulo N_DEV.
//    - A grant happens only when hold=0 and some pend_v is 1.
//    - On grant to g: change<=1, on_off<=pend_dir[g], dev_id<=g, rr_ptr<=g.
//    - Otherwise change<=0 and on_off, dev_id hold their previous values.
//  - Pending update for device i, evaluated after the grant:
//    - left = pend_v[i] & ~(granted==i).
//    - edge[i] & ~left: pend_v<=1, pend_dir<=dev_status[i].
//    - edge[i] & left: the new edge is opposite to the pending one, so cancel:
//      pend_v<=0. No event is ever issued for the pair.
//    - ~edge[i]: pend_v <= left.
//  - Consequence: a device's event granted in the same cycle as a new edge issues
//    that event and queues the new edge.
//  - busy <= |next_pend_v.
//  - Latency: a status change first sampled at posedge k is pending after k.
//    The earliest change=1 is registered at posedge k+1.
//  - Throughput: one event per cycle.
//    - Worst case after N_DEV simultaneous edges: N_DEV consecutive cycles of change=1,
//      ordered round-robin.
//  - hold=1 for any number of cycles loses no events. Edges arriving during hold may
//    still cancel against pending ones.
//  - The queue cannot overflow: each device holds at most one pending event.
// STRUCTURE
//  - Shared include iot_defs.vh holds N_DEV and ID_W defaults, the ON=1/OFF=0 encoding
//    and the reset-asserted level (1'b0).
//  - One sub-module, rr_arbiter (N, pointer in, request vector in, grant_valid and
//    grant_idx out), is purely combinational and reusable.
//  - Edge detect, pending state, output registers and rr_ptr live in the top module.
// TESTING
//  1. Reset with dev_status=8'h00, then dev_status<=8'h01. Required:
//     - change=1, on_off=1, dev_id=0 exactly one cycle after the edge is sampled.
//     - busy=0 afterwards.
//  2. Reset with dev_status=8'hFF already set. Required:
//     - 8 consecutive cycles of change=1, on_off=1.
//     - dev_id sequence 0,1,...,7; busy drops together with the last issue.
//  3. dev_status 8'h00 -> 8'h0C (bits 2,3 on). Required:
//     - dev_id 2 then 3, both on_off=1.
//     - Then 8'h0C -> 8'h04 gives one event dev_id=3, on_off=0.
//  4. Hold=1, then pulse device 5 on for 1 cycle (on then off). Required:
//     - No event is issued; busy=1 for 1 cycle, then 0.
//     - After hold releases, change stays 0.
//  5. Hold=1 while devices 1, 6 and 7 turn on. Release hold after 10 cycles. Required:
//     - Events dev_id 1, 6, 7 on three back-to-back cycles; none lost.
//  6. Reset mid-drain: rst=0 for 1 cycle during scenario 2, after the 3rd event.
//     Required:
//     - All outputs 0 and pending cleared.
//     - Because dev_status is still 8'hFF, all 8 on events re-issue starting at dev_id 0.

Source files
------------

// File: rtl/device_event_queue_pkg.sv
// Shared defaults and encodings for the IoT device event queue.
// Status levels use ON=1 / OFF=0; reset is asserted at level 0.
package device_event_queue_pkg;
    localparam int   N_DEV_DEF    = 8;
    localparam int   ID_W_DEF     = 3;
    localparam logic ON           = 1'b1;
    localparam logic OFF          = 1'b0;
    localparam logic RST_ASSERTED = 1'b0;
endpackage

// File: rtl/device_event_queue_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr+1,
// wrapping modulo N, and returns the first requester found.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  req,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);
    int idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/device_event_queue.sv
// Detects per-device on/off transitions, keeps one pending event per device
// and issues at most one event per clock in round-robin order.
module device_event_queue
    import device_event_queue_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_status,
    input  logic             hold,
    output logic             change,
    output logic             on_off,
    output logic [ID_W-1:0]  dev_id,
    output logic             busy
);
    logic [N_DEV-1:0] prev_status;
    logic [N_DEV-1:0] pend_v;
    logic [N_DEV-1:0] pend_dir;
    logic [N_DEV-1:0] edges;
    logic [N_DEV-1:0] next_pend_v;
    logic [N_DEV-1:0] next_pend_dir;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_valid;
    logic             grant;
    logic             left;

    assign edges = dev_status ^ prev_status;

    rr_arbiter #(.N(N_DEV), .IW(ID_W)) u_arb (
        .ptr         (rr_ptr),
        .req         (pend_v),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign grant = grant_valid & ~hold;

    // A new edge on a device whose event is still left pending is always the
    // opposite direction, so the pair cancels and nothing is ever issued.
    always_comb begin
        next_pend_v   = pend_v;
        next_pend_dir = pend_dir;
        left          = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            left = pend_v[i] & ~(grant && (grant_idx == ID_W'(i)));
            if (edges[i]) begin
                if (left) begin
                    next_pend_v[i] = 1'b0;
                end else begin
                    next_pend_v[i]   = 1'b1;
                    next_pend_dir[i] = dev_status[i];
                end
            end else begin
                next_pend_v[i] = left;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ASSERTED) begin
            prev_status <= '0;
            pend_v      <= '0;
            pend_dir    <= '0;
            rr_ptr      <= ID_W'(N_DEV - 1);
            change      <= 1'b0;
            on_off      <= 1'b0;
            dev_id      <= '0;
            busy        <= 1'b0;
        end else begin
            prev_status <= dev_status;
            pend_v      <= next_pend_v;
            pend_dir    <= next_pend_dir;
            busy        <= |next_pend_v;
            change      <= grant;
            if (grant) begin
                on_off <= pend_dir[grant_idx];
                dev_id <= grant_idx;
                rr_ptr <= grant_idx;
            end
        end
    end
endmodule
